dac_stream_drv: RTL and testbench
=================================

// Module: dac_stream_drv
// PURPOSE
//  Parametrised DAC output driver: streaming valid/ready input, sample FIFO, gain shift,
//  round-to-nearest width reduction with saturation, two's-complement/offset-binary coding.
//  Drives a parallel-input DAC (AD9744-class) plus its differential sample clock.
//  Sits between the DSP/DDS datapath and the DAC pins; replaces plain truncating drivers.
//  Underflow is detected, the last code is held, and a sticky flag is raised.
// PARAMETERS
//  IN_W        16  input sample width, signed two's complement
//  DAC_W       14  DAC code width; IN_W >= DAC_W required
//  FIFO_DEPTH  8   sample FIFO depth, power of two, >= 2
//  FMT_OFFSET  0   0: two's-complement DAC code, 1: offset binary (MSB inverted)
// PORTS
//  sys_clk        in   1               sample clock, rising edge
//  sys_rst_n      in   1               asynchronous active-low reset
//  s_data         in   IN_W            input sample, signed
//  s_valid        in   1               s_data valid
//  s_ready        out  1               FIFO can accept (= !full)
//  enable         in   1               1: play samples; 0: output midscale
//  gain_shift     in   3               left-shift 0..7 applied before rounding
//  clr_underflow  in   1               clears the underflow flag
//  dac_data       out  DAC_W           registered DAC code
//  clk_p / clk_n  out  1               sys_clk / ~sys_clk forwarded to DAC
//  underflow      out  1               sticky: FIFO ran empty while in RUN
//  fifo_level     out  $clog2(D)+1     current FIFO occupancy
// BEHAVIOUR
//  Reset: FIFO empty, s_ready=0 while sys_rst_n low then 1, underflow=0, state IDLE,
//   pipeline regs cleared, dac_data=MID (0 if FMT_OFFSET=0, 1<<(DAC_W-1) if 1).
//  FIFO: write on s_valid&&s_ready; a write to a full FIFO cannot occur (s_ready=0).
//   Simultaneous push/pop when full or empty is legal; level stays consistent.
//  FSM: IDLE --enable&&!empty--> RUN; RUN --empty--> STARVED (underflow<=1);
//   STARVED --!empty--> RUN; any state --!enable--> IDLE (FIFO contents kept).
//  Pop one sample per cycle in RUN only; STARVED holds last dac_data; IDLE loads MID
//   into dac_data after the pipeline drains (pipeline discarded, 1 cycle).
//  Pipeline (3 regs): S1 = sat_IN_W(x << gain_shift); S2 = round/sat to DAC_W;
//   S3 = format -> dac_data. Write at edge E0 into empty FIFO with enable=1 ->
//   pop at E1, dac_data updated at E3. Steady state: one new code per cycle.
//  Rounding: D=IN_W-DAC_W; if D>0 y=(x+2^(D-1))>>>D (round half up), saturate to
//   [-2^(DAC_W-1), 2^(DAC_W-1)-1]; if D=0 pass through. Compute in IN_W+1 bits.
//  Gain saturation: result outside IN_W signed range clamps to max/min.
//  gain_shift sampled at S1 per sample; changing mid-stream affects next popped sample.
//  underflow: set on RUN->STARVED; clr_underflow clears; set wins if same cycle.
//  clk_p/clk_n are combinational copies; no reset applied.
//  Reset mid-stream: all state cleared immediately (async), FIFO flushed, dac_data=MID.
// STRUCTURE
//  dac_pkg: midscale function, round_sat and sat_shift functions, FSM state enum
//   (IDLE, RUN, STARVED) as localparams.
//  Sub-module: dac_sync_fifo (single-clock, DEPTH/WIDTH params, level output).
//  Top holds FSM, 3-stage datapath, underflow flag, clock forwarding.
// TESTING (IN_W=16, DAC_W=14, DEPTH=8)
//  Round: gain 0, s_data 0x0005 -> 0x0001; 0x0006 -> 0x0002; 0x8000 -> 0x2000.
//  Saturate: 0x7FFF -> 0x1FFF (not wrap); gain 3, 0x1000 -> 0x7FFF -> 0x1FFF.
//  Offset mode (FMT_OFFSET=1): 0x0000 -> 0x2000; reset value dac_data 0x2000.
//  Latency/throughput: burst of 8 samples, enable=1 -> first code at E3, one per cycle
//   after; s_ready low when 8 queued with enable=0.
//  Underflow: stop s_valid after 3 samples -> dac_data holds 3rd code, underflow=1;
//   clr_underflow -> 0; resume -> RUN, outputs resume in order.
//  Async reset during burst -> dac_data=MID, fifo_level=0, underflow=0 without clock.

Source files
------------

// File: rtl/dac_stream_drv_pkg.sv
// Shared types and arithmetic helpers for the DAC stream driver.
// Helpers work on 64-bit signed values so any IN_W/DAC_W up to 56 bits fits.
package dac_stream_drv_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STARVED} state_t;

   localparam int unsigned GAIN_W = 3;

   function automatic logic [63:0] midscale(input int unsigned dac_w, input bit fmt_offset);
      return fmt_offset ? (64'd1 << (dac_w - 1)) : 64'd0;
   endfunction

   function automatic logic signed [63:0] sat_shift(input logic signed [63:0] x,
                                                    input logic [GAIN_W-1:0] sh,
                                                    input int unsigned w);
      logic signed [63:0] v, hi, lo;
      v  = x <<< sh;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Round half up, then clamp; 64 bits leaves headroom for the +half carry.
   function automatic logic signed [63:0] round_sat(input logic signed [63:0] x,
                                                    input int unsigned in_w,
                                                    input int unsigned dac_w);
      logic signed [63:0] v, hi, lo;
      int unsigned        d;
      d = in_w - dac_w;
      v = x;
      if (d != 0) v = (x + (64'sd1 <<< (d - 1))) >>> d;
      hi = (64'sd1 <<< (dac_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dac_w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/dac_stream_drv_if.sv
// Valid/ready sample stream into the DAC driver.
interface dac_stream_drv_if #(parameter int unsigned IN_W = 16);
   logic [IN_W-1:0] s_data;
   logic            s_valid;
   logic            s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dac_stream_drv_fifo.sv
// Single-clock sample FIFO with occupancy output; DEPTH must be a power of two.
module dac_sync_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_din,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_dout,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_level;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_level == (AW+1)'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_dout    = r_mem[r_rptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + AW'(1);
         if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
         if (w_do_push && !w_do_pop)      r_level <= r_level + (AW+1)'(1);
         else if (!w_do_push && w_do_pop) r_level <= r_level - (AW+1)'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_din;
   end
endmodule

// File: rtl/dac_stream_drv.sv
// DAC output driver: FIFO, gain shift, round/saturate to DAC_W, code formatting,
// underflow detection and DAC clock forwarding.
module dac_stream_drv
   import dac_stream_drv_pkg::*;
#(
   parameter int unsigned IN_W       = 16,
   parameter int unsigned DAC_W      = 14,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter bit          FMT_OFFSET = 1'b0
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst_n,
   dac_stream_drv_if.slave               s_if,
   input  logic                          enable,
   input  logic [GAIN_W-1:0]             gain_shift,
   input  logic                          clr_underflow,
   output logic [DAC_W-1:0]              dac_data,
   output logic                          clk_p,
   output logic                          clk_n,
   output logic                          underflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam logic [DAC_W-1:0] MID = DAC_W'(midscale(DAC_W, FMT_OFFSET));

   state_t                  r_state;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_pop;
   logic                    w_ready;
   logic [IN_W-1:0]         w_head;
   logic signed [IN_W-1:0]  r_s1;
   logic                    r_s1_v;
   logic signed [DAC_W-1:0] r_s2;
   logic                    r_s2_v;

   assign w_ready      = sys_rst_n && !w_full;
   assign s_if.s_ready = w_ready;
   assign w_pop        = enable && !w_empty;
   assign clk_p        = sys_clk;
   assign clk_n        = ~sys_clk;

   dac_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(IN_W)) u_fifo (
      .i_clk   (sys_clk),
      .i_rst_n (sys_rst_n),
      .i_push  (s_if.s_valid && w_ready),
      .i_din   (s_if.s_data),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (fifo_level)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state   <= ST_IDLE;
         underflow <= 1'b0;
      end else begin
         if (!enable) begin
            r_state <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE:    if (!w_empty) r_state <= ST_RUN;
               ST_RUN:     if (w_empty)  r_state <= ST_STARVED;
               ST_STARVED: if (!w_empty) r_state <= ST_RUN;
               default:    r_state <= ST_IDLE;
            endcase
         end
         if (enable && (r_state == ST_RUN) && w_empty) underflow <= 1'b1;
         else if (clr_underflow)                         underflow <= 1'b0;
      end
   end

   // Valid bits follow each popped sample; dropping enable discards in-flight samples.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_s1     <= '0;
         r_s1_v   <= 1'b0;
         r_s2     <= '0;
         r_s2_v   <= 1'b0;
         dac_data <= MID;
      end else begin
         r_s1_v <= w_pop;
         r_s1   <= IN_W'(sat_shift(64'(signed'(w_head)), gain_shift, IN_W));
         r_s2_v <= enable && r_s1_v;
         r_s2   <= DAC_W'(round_sat(64'(r_s1), IN_W, DAC_W));
         // MID doubles as the format mask: zero for two's complement, MSB for offset binary.
         if (r_state == ST_IDLE)       dac_data <= MID;
         else if (enable && r_s2_v)    dac_data <= r_s2 ^ MID;
      end
   end
endmodule

// File: tb/tb_dac_stream_drv.sv
// Self-checking bench: two-complement and offset-binary instances fed the same stream,
// vector table, directed corner sequences and a randomized run against a queue model.
module tb_dac_stream_drv;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        enable;
   logic        clr_underflow;
   logic [2:0]  gain_shift;
   logic        tb_valid;
   logic [15:0] tb_data;
   logic [13:0] dac0, dac1;
   logic        cp0, cn0, cp1, cn1, uf0, uf1;
   logic [3:0]  lvl0, lvl1;

   int n_chk = 0;
   int n_err = 0;

   always #5 sys_clk = ~sys_clk;

   dac_stream_drv_if #(.IN_W(16)) if0 ();
   dac_stream_drv_if #(.IN_W(16)) if1 ();
   assign if0.s_data  = tb_data;
   assign if0.s_valid = tb_valid;
   assign if1.s_data  = tb_data;
   assign if1.s_valid = tb_valid;

   dac_stream_drv #(.IN_W(16), .DAC_W(14), .FIFO_DEPTH(8), .FMT_OFFSET(1'b0)) dut0 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .s_if(if0), .enable(enable),
      .gain_shift(gain_shift), .clr_underflow(clr_underflow), .dac_data(dac0),
      .clk_p(cp0), .clk_n(cn0), .underflow(uf0), .fifo_level(lvl0));

   dac_stream_drv #(.IN_W(16), .DAC_W(14), .FIFO_DEPTH(8), .FMT_OFFSET(1'b1)) dut1 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .s_if(if1), .enable(enable),
      .gain_shift(gain_shift), .clr_underflow(clr_underflow), .dac_data(dac1),
      .clk_p(cp1), .clk_n(cn1), .underflow(uf1), .fifo_level(lvl1));

   typedef struct { logic [15:0] data; logic [2:0] gain; logic [13:0] code; } vec_t;
   typedef struct { int code; longint due; } pend_t;

   vec_t   vecs [13];
   int     fifo_q [$];
   pend_t  pipe_q [$];
   bit     m_active, m_starved, m_uf;
   int     m_dac;
   longint m_cyc;

   // Expected two's-complement DAC code from plain integer arithmetic.
   function automatic int model_code(input int x, input int g);
      longint v, r, q;
      v = x;
      for (int i = 0; i < g; i++) v = v * 2;
      if (v > 32767)  v = 32767;
      if (v < -32768) v = -32768;
      r = v + 2;
      q = (r >= 0) ? r / 4 : -((-r + 3) / 4);
      if (q > 8191)  q = 8191;
      if (q < -8192) q = -8192;
      return int'(q & 64'h3FFF);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      fifo_q.delete();
      pipe_q.delete();
      m_active  = 1'b0;
      m_starved = 1'b0;
      m_uf      = 1'b0;
      m_dac     = 0;
   endtask

   task automatic model_step();
      bit en, empty, full, was_idle, in_run;
      int x;
      en       = enable;
      empty    = (fifo_q.size() == 0);
      full     = (fifo_q.size() >= 8);
      was_idle = !m_active;
      in_run   = m_active && !m_starved;
      if (en && in_run && empty) m_uf = 1'b1;
      else if (clr_underflow)    m_uf = 1'b0;
      if (!en) begin
         m_active  = 1'b0;
         m_starved = 1'b0;
      end else if (!m_active) begin
         if (!empty) m_active = 1'b1;
      end else if (!m_starved) begin
         if (empty) m_starved = 1'b1;
      end else if (!empty) begin
         m_starved = 1'b0;
      end
      if (was_idle) m_dac = 0;
      else if (en && pipe_q.size() > 0 && pipe_q[0].due == m_cyc) begin
         m_dac = pipe_q[0].code;
         void'(pipe_q.pop_front());
      end
      if (!en) pipe_q.delete();
      if (en && !empty) begin
         x = fifo_q.pop_front();
         pipe_q.push_back('{model_code(x, int'(gain_shift)), m_cyc + 2});
      end
      if (tb_valid && !full) fifo_q.push_back(int'($signed(tb_data)));
   endtask

   task automatic compare_all();
      chk("dac_data",        32'(dac0), 32'(m_dac));
      chk("dac_data_offset", 32'(dac1), 32'(m_dac ^ 'h2000));
      chk("underflow",       32'(uf0),  32'(m_uf));
      chk("underflow_offset",32'(uf1),  32'(m_uf));
      chk("fifo_level",      32'(lvl0), 32'(fifo_q.size()));
      chk("s_ready",         32'(if0.s_ready), 32'(sys_rst_n && (fifo_q.size() < 8)));
   endtask

   task automatic tick();
      @(posedge sys_clk);
      if (!sys_rst_n) model_reset();
      else            model_step();
      m_cyc++;
      @(negedge sys_clk);
      compare_all();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{16'h0005, 3'd0, 14'h0001};
      vecs[1]  = '{16'h0006, 3'd0, 14'h0002};
      vecs[2]  = '{16'h8000, 3'd0, 14'h2000};
      vecs[3]  = '{16'h7FFF, 3'd0, 14'h1FFF};
      vecs[4]  = '{16'h1000, 3'd3, 14'h1FFF};
      vecs[5]  = '{16'h0000, 3'd0, 14'h0000};
      vecs[6]  = '{16'hFFFA, 3'd0, 14'h3FFF};
      vecs[7]  = '{16'hFFF9, 3'd0, 14'h3FFE};
      vecs[8]  = '{16'h0002, 3'd0, 14'h0001};
      vecs[9]  = '{16'hFFFF, 3'd7, 14'h3FE0};
      vecs[10] = '{16'hC000, 3'd2, 14'h2000};
      vecs[11] = '{16'h0100, 3'd1, 14'h0080};
      vecs[12] = '{16'hFFFE, 3'd0, 14'h0000};

      sys_rst_n = 1'b0; enable = 1'b0; clr_underflow = 1'b0;
      gain_shift = 3'd0; tb_valid = 1'b0; tb_data = '0;
      model_reset();
      m_cyc = 0;

      // Reset state
      @(negedge sys_clk);
      chk("rst_dac",        32'(dac0), 32'h0000);
      chk("rst_dac_offset", 32'(dac1), 32'h2000);
      chk("rst_s_ready",    32'(if0.s_ready), 32'h0);
      chk("rst_level",      32'(lvl0), 32'h0);
      chk("rst_underflow",  32'(uf0),  32'h0);
      chk("clk_p_low",      32'(cp0),  32'h0);
      chk("clk_n_high",     32'(cn0),  32'h1);
      tick();
      sys_rst_n = 1'b1;
      tick();
      chk("s_ready_after_rst", 32'(if0.s_ready), 32'h1);

      // Single-sample vectors: write at E0, code visible after E3
      enable = 1'b1;
      for (int i = 0; i < 13; i++) begin
         gain_shift = vecs[i].gain;
         tb_data    = vecs[i].data;
         tb_valid   = 1'b1;
         tick();
         tb_valid   = 1'b0;
         tick();
         tick();
         tick();
         chk($sformatf("vec%0d_code", i),        32'(dac0), 32'(vecs[i].code));
         chk($sformatf("vec%0d_code_offset", i), 32'(dac1), 32'(vecs[i].code ^ 14'h2000));
         tick();
      end
      gain_shift = 3'd0;

      // Burst of 8 queued while disabled, then played back one per cycle
      enable = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         tb_data  = 16'(4 * i);
         tb_valid = 1'b1;
         tick();
      end
      tb_data = 16'h7777;
      tick();
      chk("full_level",   32'(lvl0), 32'd8);
      chk("full_s_ready", 32'(if0.s_ready), 32'h0);
      tb_valid = 1'b0;
      enable   = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("burst_code%0d", i), 32'(dac0), 32'(i));
      end

      // Underflow: three samples, hold last code, clear, resume
      clr_underflow = 1'b1;
      tick();
      clr_underflow = 1'b0;
      chk("uf_cleared_pre", 32'(uf0), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tb_data  = 16'(40 + 4 * i);
         tb_valid = 1'b1;
         tick();
      end
      tb_valid = 1'b0;
      repeat (6) tick();
      chk("hold_third_code", 32'(dac0), 32'd12);
      chk("uf_set",          32'(uf0),  32'h1);
      clr_underflow = 1'b1;
      tick();
      clr_underflow = 1'b0;
      chk("uf_cleared", 32'(uf0), 32'h0);
      tb_data = 16'd52; tb_valid = 1'b1;
      tick();
      tb_data = 16'd56;
      tick();
      tb_valid = 1'b0;
      tick();
      tick();
      chk("resume_code13", 32'(dac0), 32'd13);
      tick();
      chk("resume_code14", 32'(dac0), 32'd14);

      // Asynchronous reset in the middle of a burst
      for (int i = 0; i < 4; i++) begin
         tb_data  = 16'(100 + 4 * i);
         tb_valid = 1'b1;
         tick();
      end
      #2 sys_rst_n = 1'b0;
      #1;
      chk("arst_dac",        32'(dac0), 32'h0000);
      chk("arst_dac_offset", 32'(dac1), 32'h2000);
      chk("arst_level",      32'(lvl0), 32'h0);
      chk("arst_underflow",  32'(uf0),  32'h0);
      chk("arst_s_ready",    32'(if0.s_ready), 32'h0);
      model_reset();
      tb_valid = 1'b0;
      tick();
      tick();
      sys_rst_n = 1'b1;
      tick();

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         tb_valid = ($urandom_range(0, 99) < 65);
         case ($urandom_range(0, 9))
            0:       tb_data = 16'h7FFF;
            1:       tb_data = 16'h8000;
            default: tb_data = 16'($urandom);
         endcase
         if ($urandom_range(0, 9) == 0) gain_shift = 3'($urandom_range(0, 7));
         enable        = ($urandom_range(0, 99) < 93);
         clr_underflow = ($urandom_range(0, 99) < 6);
         tick();
      end
      chk("clk_p_random", 32'(cp1), 32'h0);
      chk("clk_n_random", 32'(cn1), 32'h1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
